vote_button_conditioner: RTL
============================

// Module: vote_button_conditioner
// PURPOSE
//  Front-end stage feeding the voting machine. Takes raw, asynchronous, bouncy
//  candidate buttons and the mode switch, and synchronises them. Debounces the
//  buttons and emits exactly one single-cycle, one-hot vote strobe per clean
//  press. Simultaneous presses are rejected; a press is never counted twice.
// PARAMETERS
//  N_BUTTONS        3    number of candidate buttons
//  DEBOUNCE_CYCLES  16   consecutive stable cycles required to accept a press (>=2)
//  LOCKOUT_CYCLES   32   consecutive all-released cycles before the next press is accepted (>=1)
// PORTS
//  clock        in   1          system clock, rising edge
//  reset        in   1          asynchronous, active-low reset
//  mode_raw     in   1          raw mode switch (0 = voting, 1 = result display)
//  button_raw   in   N_BUTTONS  raw candidate buttons, active-high, asynchronous
//  mode         out  1          synchronised mode, drives the voting machine's mode input
//  vote_valid   out  1          1-cycle strobe: one accepted vote
//  vote_id      out  N_BUTTONS  one-hot candidate; valid only when vote_valid=1, else 0
//  conflict     out  1          1-cycle strobe: multi-button press was rejected
//  busy         out  1          1 while FSM is not IDLE
// BEHAVIOUR
//  - Reset (async assert, sync deassert internally): all outputs 0, synchroniser flops 0, FSM IDLE, counter 0.
//  - Each button_raw bit and mode_raw passes through a 2-flop synchroniser. s = synced button vector.
//  - Counter width = $clog2(max(DEBOUNCE_CYCLES,LOCKOUT_CYCLES)+1).
//  - FSM states: IDLE, DEBOUNCE, HELD, LOCKOUT.
//    IDLE:     if s!=0, capture cand<=s, cnt<=0, go to DEBOUNCE.
//    DEBOUNCE: if s!=cand, go to IDLE (bounce, nothing emitted). Else cnt++.
//              At cnt==DEBOUNCE_CYCLES-1 (still s==cand), go to HELD and take one action:
//              - cand one-hot: vote_valid=1, vote_id=cand for the next cycle only.
//              - cand has >1 bit set: conflict=1 for the next cycle only.
//    HELD:     wait for s==0. Extra buttons pressed here are ignored. On s==0, cnt<=0 and go to LOCKOUT.
//    LOCKOUT:  if s!=0, cnt<=0 and stay (bounce on release). Else cnt++.
//              At cnt==LOCKOUT_CYCLES-1, go to IDLE.
//  - Latency: from the first clock edge sampling raw high to vote_valid high is DEBOUNCE_CYCLES+3 cycles.
//  - vote_valid, vote_id and conflict are registered outputs. vote_valid and conflict are never both high.
//  - Mode masking: when mode=1 at the acceptance cycle, vote_valid and conflict stay 0, but the FSM still
//    enters HELD. This prevents a button held across a mode change from voting on return.
//  - Mode change has no effect on FSM state otherwise.
//  - A button held continuously yields exactly one strobe, whatever its duration.
//  - Reset asserted mid-press: immediate return to IDLE, outputs 0. A press still held after reset
//    release is debounced afresh and counts once.
// CONFIGURATION
//  VOTE_CONFLICT_CNT_EN defined:
//   - adds output conflict_count[7:0]. It resets to 0, increments on each conflict strobe,
//     saturates at 255 and is cleared only by reset.
//  Not defined: the port and counter are absent. conflict behaviour is unchanged.
// STRUCTURE
//  - vote_pkg holds: typedef enum logic[1:0] {IDLE,DEBOUNCE,HELD,LOCKOUT} cond_state_t,
//    the default N_BUTTONS constant, and the one-hot check function is_onehot().
//  - One sub-module: sync_2ff (parameterised width, async active-low reset), used for
//    the button vector and mode.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=3, N_BUTTONS=3)
//  1. Reset low 10 cycles, then high -> all outputs 0, busy=0.
//  2. button_raw=3'b001 held 20 cycles -> exactly one vote_valid, vote_id=3'b001,
//     7 cycles after the first sampling edge.
//  3. button_raw=3'b010 toggling every 2 cycles for 12 cycles, then released ->
//     no vote_valid, FSM back to IDLE, busy=0.
//  4. button_raw=3'b110 held 10 cycles -> conflict=1 for one cycle, vote_valid never 1.
//     With VOTE_CONFLICT_CNT_EN, conflict_count=1.
//  5. 3'b100 press accepted, released for 1 cycle, pressed again for 10 cycles -> only one vote.
//     Then release 3+ cycles and press -> second vote, vote_id=3'b100.
//  6. mode_raw=1, button_raw=3'b001 held 10 cycles -> mode=1 after 2 cycles, no vote_valid.
//     Switch mode to 0 while the button is still held -> still no vote.
//     Then release and press again -> vote.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote button conditioner.
package vote_pkg;

    localparam int unsigned N_BUTTONS_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        LOCKOUT
    } cond_state_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, async active-low reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/vote_button_conditioner.sv
// Synchronises and debounces candidate buttons into single-cycle one-hot vote strobes.
// Optional VOTE_CONFLICT_CNT_EN adds a saturating 8-bit conflict_count output.
module vote_button_conditioner
    import vote_pkg::*;
#(
    parameter int unsigned N_BUTTONS       = N_BUTTONS_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LOCKOUT_CYCLES  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mode_raw,
    input  logic [N_BUTTONS-1:0] button_raw,
    output logic                 mode,
    output logic                 vote_valid,
    output logic [N_BUTTONS-1:0] vote_id,
    output logic                 conflict,
    output logic                 busy
`ifdef VOTE_CONFLICT_CNT_EN
    ,
    output logic [7:0]           conflict_count
`endif
);

    localparam int unsigned MAX_CYC = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES
                                                                          : LOCKOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    logic                 rst_sync_n;
    logic [N_BUTTONS-1:0] btn_s;

    cond_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_BUTTONS-1:0] cand_q, cand_d;
    logic                 vote_valid_d;
    logic [N_BUTTONS-1:0] vote_id_d;
    logic                 conflict_d;

    // Reset asserts asynchronously but releases on a clock edge.
    sync_2ff #(.WIDTH(1)) u_rst_sync (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (1'b1),
        .q_o    (rst_sync_n)
    );

    sync_2ff #(.WIDTH(N_BUTTONS)) u_btn_sync (
        .clk_i  (clock),
        .rst_ni (rst_sync_n),
        .d_i    (button_raw),
        .q_o    (btn_s)
    );

    sync_2ff #(.WIDTH(1)) u_mode_sync (
        .clk_i  (clock),
        .rst_ni (rst_sync_n),
        .d_i    (mode_raw),
        .q_o    (mode)
    );

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= '0;
            vote_valid <= 1'b0;
            vote_id    <= '0;
            conflict   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            vote_valid <= vote_valid_d;
            vote_id    <= vote_id_d;
            conflict   <= conflict_d;
            busy       <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        vote_valid_d = 1'b0;
        vote_id_d    = '0;
        conflict_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (btn_s != '0) begin
                    cand_d  = btn_s;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (btn_s != cand_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    // Enter HELD even in display mode so the press cannot vote later.
                    state_d = HELD;
                    if (!mode) begin
                        if (is_onehot(32'(cand_q))) begin
                            vote_valid_d = 1'b1;
                            vote_id_d    = cand_q;
                        end else begin
                            conflict_d   = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (btn_s == '0) begin
                    cnt_d   = '0;
                    state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (btn_s != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(LOCKOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef VOTE_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt_q;

    // Counts alongside the conflict strobe, saturating at 255.
    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            conflict_cnt_q <= 8'd0;
        end else if (conflict_d && (conflict_cnt_q != 8'hFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 8'd1;
        end
    end

    assign conflict_count = conflict_cnt_q;
`else
    // Conflict strobes are not tallied in this build.
`endif

endmodule
